// File: rtl/mips_pipe_pkg.sv
// Shared widths, control-bit positions and payload sizing for the MIPS pipeline registers.
package mips_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int WB_W_DEF   = 2;
    localparam int M_W_DEF    = 3;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    localparam int M_BRANCH    = 2;
    localparam int M_MEM_READ  = 1;
    localparam int M_MEM_WRITE = 0;

    // Branch target, ALU result and store data are DATA_W each; plus the zero flag.
    function automatic int pay_w(input int data_w, input int reg_w,
                                 input int wb_w, input int m_w);
        return wb_w + m_w + 3 * data_w + 1 + reg_w;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_skid.sv
// Generic two-entry valid/ready skid buffer with flush; main entry drives the outputs.
// Latency 1 cycle; in_ready is registered and drops only once the skid entry is occupied.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);

    logic         m_vld_q, m_vld_d;
    logic [W-1:0] m_dat_q, m_dat_d;
    logic         s_vld_q, s_vld_d;
    logic [W-1:0] s_dat_q, s_dat_d;
    logic         rdy_q, rdy_d;
    logic         accept;
    logic         drain;

    assign accept = in_vld_i & rdy_q;
    assign drain  = m_vld_q & out_rdy_i;

    always_comb begin
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        if (flush_i) begin
            // A beat accepted this cycle is dropped along with the held ones.
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (!m_vld_q || drain) begin
            if (s_vld_q) begin
                m_vld_d = 1'b1;
                m_dat_d = s_dat_q;
                s_vld_d = 1'b0;
            end else if (accept) begin
                m_vld_d = 1'b1;
                m_dat_d = in_dat_i;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (accept) begin
            s_vld_d = 1'b1;
            s_dat_d = in_dat_i;
        end
        rdy_d = !s_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            m_dat_q <= '0;
            s_vld_q <= 1'b0;
            s_dat_q <= '0;
            rdy_q   <= 1'b1;
        end else begin
            m_vld_q <= m_vld_d;
            m_dat_q <= m_dat_d;
            s_vld_q <= s_vld_d;
            s_dat_q <= s_dat_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_vld_o = m_vld_q;
    assign out_dat_o = m_dat_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: packs EX results into a skid buffer, masks WB/M control on bubbles.
// Latency 1 cycle; out_ready low stalls, one extra beat is absorbed before in_ready drops.
module ex_mem_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int WB_W   = WB_W_DEF,
    parameter int M_W    = M_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   ctlwb_in,
    input  logic [M_W-1:0]    ctlm_in,
    input  logic [DATA_W-1:0] branch_tgt_in,
    input  logic              alu_zero_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [REG_W-1:0]  dest_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   ctlwb_out,
    output logic [M_W-1:0]    ctlm_out,
    output logic [DATA_W-1:0] branch_tgt_out,
    output logic              alu_zero_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [REG_W-1:0]  dest_reg_out
);

    localparam int PAY_W = pay_w(DATA_W, REG_W, WB_W, M_W);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] branch_tgt;
        logic              alu_zero;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  dest_reg;
    } pay_t;

    pay_t pay_in;
    pay_t pay_out;

    assign pay_in = '{wb: ctlwb_in, m: ctlm_in, branch_tgt: branch_tgt_in,
                      alu_zero: alu_zero_in, alu_result: alu_result_in,
                      store_data: store_data_in, dest_reg: dest_reg_in};

    skid_buffer #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .in_vld_i  (in_valid),
        .in_rdy_o  (in_ready),
        .in_dat_i  (pay_in),
        .out_vld_o (out_valid),
        .out_rdy_i (out_ready),
        .out_dat_o (pay_out)
    );

    // Zeroed control turns a bubble into a no-op for MEM and WB; data is left as-is.
    assign ctlwb_out      = out_valid ? pay_out.wb : '0;
    assign ctlm_out       = out_valid ? pay_out.m  : '0;
    assign branch_tgt_out = pay_out.branch_tgt;
    assign alu_zero_out   = pay_out.alu_zero;
    assign alu_result_out = pay_out.alu_result;
    assign store_data_out = pay_out.store_data;
    assign dest_reg_out   = pay_out.dest_reg;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: reset, streaming, stall/skid, flush, bubble masking.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ctlwb_in;
    logic [2:0]  ctlm_in;
    logic [31:0] branch_tgt_in;
    logic        alu_zero_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  dest_reg_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  ctlwb_out;
    logic [2:0]  ctlm_out;
    logic [31:0] branch_tgt_out;
    logic        alu_zero_out;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [4:0]  dest_reg_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ctlwb_in       (ctlwb_in),
        .ctlm_in        (ctlm_in),
        .branch_tgt_in  (branch_tgt_in),
        .alu_zero_in    (alu_zero_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .dest_reg_in    (dest_reg_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ctlwb_out      (ctlwb_out),
        .ctlm_out       (ctlm_out),
        .branch_tgt_out (branch_tgt_out),
        .alu_zero_out   (alu_zero_out),
        .alu_result_out (alu_result_out),
        .store_data_out (store_data_out),
        .dest_reg_out   (dest_reg_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Derive all payload fields from the ALU result so one number identifies a beat.
    task automatic beat(input logic vld, input logic [31:0] res);
        in_valid      = vld;
        alu_result_in = res;
        branch_tgt_in = res + 32'h100;
        store_data_in = res + 32'h1000;
        alu_zero_in   = (res == 32'h0);
        dest_reg_in   = res[4:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        ctlwb_in = 2'b10; ctlm_in = 3'b010;
        beat(1'b1, 32'h99);
        #1;
        tick; tick;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_result", 64'(alu_result_out), 64'd0);
        chk("rst_branch_tgt", 64'(branch_tgt_out), 64'd0);
        chk("rst_store_data", 64'(store_data_out), 64'd0);
        chk("rst_dest_reg", 64'(dest_reg_out), 64'd0);
        chk("rst_ctlwb", 64'(ctlwb_out), 64'd0);
        chk("rst_ctlm", 64'(ctlm_out), 64'd0);

        rst = 1'b0;
        beat(1'b0, 32'h99);
        tick;
        chk("post_rst_no_beat", 64'(out_valid), 64'd0);

        beat(1'b1, 32'h10);
        tick;
        chk("s0_valid", 64'(out_valid), 64'd1);
        chk("s0_alu", 64'(alu_result_out), 64'h10);
        chk("s0_ctlwb", 64'(ctlwb_out), 64'h2);
        chk("s0_ctlm", 64'(ctlm_out), 64'h2);
        chk("s0_store", 64'(store_data_out), 64'h1010);
        chk("s0_btgt", 64'(branch_tgt_out), 64'h110);
        chk("s0_dest", 64'(dest_reg_out), 64'h10);

        beat(1'b1, 32'h20);
        tick;
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk("s1_alu", 64'(alu_result_out), 64'h20);

        // Stall with 0x20 in the main entry while 0x30 is offered.
        out_ready = 1'b0;
        beat(1'b1, 32'h30);
        tick;
        chk("stall_alu_hold", 64'(alu_result_out), 64'h20);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);

        beat(1'b1, 32'h40);
        tick;
        chk("stall2_alu_hold", 64'(alu_result_out), 64'h20);
        chk("stall2_in_ready", 64'(in_ready), 64'd0);

        out_ready = 1'b1;
        tick;
        chk("rel_alu_30", 64'(alu_result_out), 64'h30);
        chk("rel_valid", 64'(out_valid), 64'd1);
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        tick;
        chk("rel_alu_40", 64'(alu_result_out), 64'h40);
        chk("rel_valid2", 64'(out_valid), 64'd1);

        // Bubble: no beat offered, control inputs changed.
        ctlm_in = 3'b001;
        beat(1'b0, 32'h77);
        tick;
        chk("bub_valid", 64'(out_valid), 64'd0);
        chk("bub_ctlm", 64'(ctlm_out), 64'd0);
        chk("bub_ctlwb", 64'(ctlwb_out), 64'd0);
        chk("bub_alu_hold", 64'(alu_result_out), 64'h40);
        chk("bub_store_hold", 64'(store_data_out), 64'h1040);
        ctlm_in = 3'b010;

        // Fill both entries, then flush.
        out_ready = 1'b0;
        beat(1'b1, 32'h50);
        tick;
        chk("fill_m_alu", 64'(alu_result_out), 64'h50);
        beat(1'b1, 32'h60);
        tick;
        chk("fill_s_in_ready", 64'(in_ready), 64'd0);
        chk("fill_s_alu", 64'(alu_result_out), 64'h50);

        flush = 1'b1;
        beat(1'b1, 32'h66);
        tick;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctlwb", 64'(ctlwb_out), 64'd0);
        chk("flush_ctlm", 64'(ctlm_out), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);

        // Flush with a beat accepted in the same cycle: it must vanish.
        out_ready = 1'b1;
        beat(1'b1, 32'h55);
        tick;
        chk("flush55_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        beat(1'b0, 32'h0);
        tick;
        chk("flush55_valid2", 64'(out_valid), 64'd0);
        chk("flush55_alu_hold", 64'(alu_result_out), 64'h50);

        beat(1'b1, 32'h70);
        tick;
        chk("recover_valid", 64'(out_valid), 64'd1);
        chk("recover_alu", 64'(alu_result_out), 64'h70);

        // Reset during a stall with both entries full.
        out_ready = 1'b0;
        beat(1'b1, 32'h80);
        tick;
        beat(1'b1, 32'h90);
        tick;
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick;
        chk("stall_rst_valid", 64'(out_valid), 64'd0);
        chk("stall_rst_in_ready", 64'(in_ready), 64'd1);
        chk("stall_rst_alu", 64'(alu_result_out), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        beat(1'b0, 32'h0);
        tick;
        chk("stall_rst_no_beat", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
